fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter size, default 8, giving the data width in bits (matches the FIFO word width).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the CLOCK cycles per serial bit (minimum 2).
REQ-003 The block SHALL have parameter PARITY_EN, default 0; when 1 an even-parity bit is sent after the data bits.
REQ-004 The block SHALL have port CLOCK, input, 1 bit: system clock; all state changes on the rising edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port ENABLE, input, 1 bit: permits fetching and starting new frames.
REQ-007 The block SHALL have port F_EMPTY_N, input, 1 bit: FIFO non-empty flag, 1 = at least one word available.
REQ-008 The block SHALL have port FIFO_DATA, input, size bits: FIFO read data, valid the cycle after READ.
REQ-009 The block SHALL have port READ, output, 1 bit: FIFO read strobe, at most one cycle per frame.
REQ-010 The block SHALL have port TX, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high whenever state is not IDLE.
REQ-012 The block SHALL have port FRAME_DONE, output, 1 bit: one-cycle pulse in the last cycle of the stop bit.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, CAPT, START, DATA, PARITY and STOP, encoded as a registered enum.
REQ-014 IDLE SHALL go to REQ on the edge where ENABLE=1 and F_EMPTY_N=1; otherwise it SHALL stay in IDLE.
REQ-015 READ SHALL be 1 only while in REQ, so READ is a single-cycle pulse; REQ SHALL always go to CAPT.
REQ-016 In CAPT the shift register SHALL load FIFO_DATA on the edge ending CAPT, parity SHALL be computed from FIFO_DATA, and the FSM SHALL go to START.
REQ-017 START SHALL drive TX=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-018 DATA SHALL send size bits LSB first, each held for exactly CLKS_PER_BIT cycles, with the bit index counting 0..size-1.
REQ-019 After the last data bit the FSM SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-020 PARITY SHALL drive the XOR of the 8 captured bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
REQ-021 STOP SHALL drive TX=1 for CLKS_PER_BIT cycles, with FRAME_DONE=1 in the final cycle.
REQ-022 At the end of STOP the FSM SHALL go to REQ if ENABLE=1 and F_EMPTY_N=1, else to IDLE.
REQ-023 Back-to-back frames SHALL have exactly 2 TX=1 cycles (REQ, CAPT) between the stop-bit end and the next start bit.
REQ-024 TX SHALL be 1 in IDLE, REQ and CAPT.
REQ-025 TX SHALL be driven from a register, so it is glitch-free.
REQ-026 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, SHALL reset to 0 on every bit boundary, and SHALL never exceed CLKS_PER_BIT-1.
REQ-027 Deasserting ENABLE mid-frame SHALL NOT abort the frame; the frame SHALL complete and no further READ SHALL be issued.
REQ-028 F_EMPTY_N SHALL be ignored outside IDLE and the STOP final cycle.
REQ-029 The block SHALL never assert READ while F_EMPTY_N=0.
REQ-030 Total frame length SHALL be (size+2+PARITY_EN)*CLKS_PER_BIT cycles, measured from start-bit start to stop-bit end.

Reset
REQ-031 When RESET_N=0, the block SHALL immediately set state=IDLE, TX=1, READ=0, BUSY=0, FRAME_DONE=0, and clear the baud counter, bit counter and shift register.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; the fetched word is lost, and no READ SHALL occur until ENABLE=1, F_EMPTY_N=1 and RESET_N has been 1 for at least one edge.

Verification
REQ-033 Single byte (CLKS_PER_BIT=4, PARITY_EN=0): FIFO holds 0xA5, ENABLE=1 -> exactly one READ pulse; start bit begins 2 cycles after READ rises; TX carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; FRAME_DONE pulses once at cycle 40 of the frame.
REQ-034 Parity (PARITY_EN=1): bytes 0xA5 then 0x07 -> parity bits 0 and 1; each frame is 44 cycles.
REQ-035 Back-to-back: FIFO holds 3 words -> 3 READ pulses, 2 TX=1 gap cycles between frames, and a 4th READ never issues once F_EMPTY_N=0.
REQ-036 ENABLE drop: ENABLE=0 during the data bits of frame 1 with 2 words queued -> frame 1 completes, no further READ, BUSY falls after STOP.
REQ-037 Reset mid-frame: RESET_N=0 during DATA bit 3 -> TX=1 and BUSY=0 asynchronously; after release with ENABLE=1 and a non-empty FIFO, a new READ issues and the next word is sent intact.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_uart_tx : pulls words from a FIFO and serialises them as UART frames  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fifo_uart_tx #(
  parameter int size         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  input  logic            ENABLE,
  input  logic            F_EMPTY_N,
  input  logic [size-1:0] FIFO_DATA,
  output logic            READ,
  output logic            TX,
  output logic            BUSY,
  output logic            FRAME_DONE
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(size - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] CAPT   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] PARITY = 3'd5;
  localparam logic [2:0] STOP   = 3'd6;

  logic [2:0]       state, state_next;
  logic [CNT_W-1:0] baud, baud_next;
  logic [BIT_W-1:0] bit_idx, bit_idx_next;
  logic [size-1:0]  shift, shift_next;
  logic             par, par_next;
  logic             tx_q, tx_next;
  logic             bit_end;

  assign bit_end = (baud == BAUD_LAST);

  always_comb begin
    state_next   = state;
    baud_next    = baud;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    par_next     = par;
    tx_next      = tx_q;
    case (state)
      IDLE: begin
        if (ENABLE && F_EMPTY_N) state_next = REQ;
      end
      REQ: begin
        state_next = CAPT;
      end
      CAPT: begin
        shift_next   = FIFO_DATA;
        par_next     = ^FIFO_DATA;
        baud_next    = '0;
        bit_idx_next = '0;
        tx_next      = 1'b0;
        state_next   = START;
      end
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          tx_next    = shift[0];
          state_next = DATA;
        end else begin
          baud_next = baud + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_idx == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_next    = par;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            // shift first so the next bit to send is always at position 0
            shift_next   = shift >> 1;
            tx_next      = shift_next[0];
            bit_idx_next = bit_idx + BIT_W'(1);
          end
        end else begin
          baud_next = baud + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = STOP;
        end else begin
          baud_next = baud + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = (ENABLE && F_EMPTY_N) ? REQ : IDLE;
        end else begin
          baud_next = baud + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      par     <= par_next;
      tx_q    <= tx_next;
    end
  end

  assign TX         = tx_q;
  assign READ       = (state == REQ);
  assign BUSY       = (state != IDLE);
  assign FRAME_DONE = (state == STOP) && bit_end;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_uart_tx : directed/random frames against a frame-level reference   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] en = 2'b00;
  logic [1:0] fe;
  logic [1:0] rd, tx, busy, done;
  logic [7:0] fifo_data [2];
  logic [7:0] mem [2][16];
  int         wp [2] = '{0, 0};
  int         rp [2] = '{0, 0};
  logic       rd_empty = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  // dut 0 without parity, dut 1 with parity; each has its own FIFO
  fifo_uart_tx #(.size(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .CLOCK(clock), .RESET_N(reset_n), .ENABLE(en[0]), .F_EMPTY_N(fe[0]),
    .FIFO_DATA(fifo_data[0]), .READ(rd[0]), .TX(tx[0]), .BUSY(busy[0]),
    .FRAME_DONE(done[0]));

  fifo_uart_tx #(.size(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .CLOCK(clock), .RESET_N(reset_n), .ENABLE(en[1]), .F_EMPTY_N(fe[1]),
    .FIFO_DATA(fifo_data[1]), .READ(rd[1]), .TX(tx[1]), .BUSY(busy[1]),
    .FRAME_DONE(done[1]));

  assign fe[0] = (wp[0] != rp[0]);
  assign fe[1] = (wp[1] != rp[1]);

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (rd[k] === 1'b1) begin
        if (wp[k] == rp[k]) rd_empty <= 1'b1;
        fifo_data[k] <= mem[k][rp[k] % 16];
        rp[k]        <= rp[k] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    mem[k][wp[k] % 16] = d;
    wp[k] = wp[k] + 1;
  endtask

  task automatic wait_read(input int k, output int waited);
    waited = 0;
    @(negedge clock);
    while (rd[k] !== 1'b1 && waited < 300) begin
      @(negedge clock);
      waited++;
    end
  endtask

  // Expected line is start, 8 data bits LSB first, optional even parity, stop.
  task automatic check_frame(input int k, input logic [7:0] d, input bit par_on,
                             input bit b2b, input int drop_at, input string tag);
    int          waited, n;
    bit          bits [$];
    logic [63:0] obs_tx, exp_tx, obs_done, exp_done, obs_busy;
    n = (10 + (par_on ? 1 : 0)) * CPB;
    bits.push_back(1'b0);
    for (int j = 0; j < 8; j++) bits.push_back(d[j]);
    if (par_on) bits.push_back(($countones(d) % 2) == 1);
    bits.push_back(1'b1);
    wait_read(k, waited);
    chk({tag, " read"}, 64'(rd[k]), 64'd1);
    if (b2b) chk({tag, " gap"}, 64'(waited), 64'd0);
    @(negedge clock);
    chk({tag, " capt rd/tx/busy"}, {61'd0, rd[k], tx[k], busy[k]}, 64'b011);
    obs_tx = '0; exp_tx = '0; obs_done = '0; exp_done = '0; obs_busy = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (i == drop_at) en[k] = 1'b0;
      obs_tx[i]   = tx[k];
      exp_tx[i]   = bits[i / CPB];
      obs_done[i] = done[k];
      exp_done[i] = (i == n - 1);
      obs_busy[i] = busy[k] & ~rd[k];
    end
    chk({tag, " tx"}, obs_tx, exp_tx);
    chk({tag, " done"}, obs_done, exp_done);
    chk({tag, " busy"}, obs_busy, (64'd1 << n) - 64'd1);
  endtask

  task automatic no_read(input int k, input int cycles, input string tag);
    int cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (rd[k] === 1'b1) cnt++;
    end
    chk({tag, " no read"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    logic [7:0] w [4];
    int         waited;

    // reset state
    repeat (3) @(negedge clock);
    chk("reset tx", 64'(tx), 64'b11);
    chk("reset rd/busy/done", {58'd0, rd, busy, done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post-reset idle", {58'd0, rd, busy, done}, 64'd0);

    // single byte, no parity
    push(0, 8'hA5);
    en[0] = 1'b1;
    check_frame(0, 8'hA5, 1'b0, 1'b0, -1, "a5");
    @(negedge clock);
    chk("a5 idle busy", 64'(busy[0]), 64'd0);
    no_read(0, 30, "a5");
    en[0] = 1'b0;

    // parity pair on dut 1
    push(1, 8'hA5);
    push(1, 8'h07);
    en[1] = 1'b1;
    check_frame(1, 8'hA5, 1'b1, 1'b0, -1, "par a5");
    check_frame(1, 8'h07, 1'b1, 1'b1, -1, "par 07");
    no_read(1, 30, "par");
    en[1] = 1'b0;

    // three random words back to back
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      push(0, w[i]);
    end
    en[0] = 1'b1;
    check_frame(0, w[0], 1'b0, 1'b0, -1, "b2b0");
    check_frame(0, w[1], 1'b0, 1'b1, -1, "b2b1");
    check_frame(0, w[2], 1'b0, 1'b1, -1, "b2b2");
    no_read(0, 40, "b2b");

    // enable dropped during the data bits of the first of two queued words
    w[0] = 8'($urandom_range(0, 255));
    w[1] = 8'($urandom_range(0, 255));
    en[0] = 1'b0;
    push(0, w[0]);
    push(0, w[1]);
    en[0] = 1'b1;
    check_frame(0, w[0], 1'b0, 1'b0, 4 * CPB, "drop");
    @(negedge clock);
    chk("drop busy low", 64'(busy[0]), 64'd0);
    no_read(0, 40, "drop");
    en[0] = 1'b1;
    check_frame(0, w[1], 1'b0, 1'b0, -1, "drop resume");

    // reset during data bit 3, then the next queued word goes out whole
    w[2] = 8'($urandom_range(0, 255));
    w[3] = 8'($urandom_range(0, 255));
    push(0, w[2]);
    push(0, w[3]);
    wait_read(0, waited);
    chk("rst read", 64'(rd[0]), 64'd1);
    repeat (19) @(negedge clock);
    chk("rst bit3 tx", 64'(tx[0]), 64'(w[2][3]));
    reset_n = 1'b0;
    #1;
    chk("rst async tx/busy/rd/done", {60'd0, tx[0], busy[0], rd[0], done[0]}, 64'b1000);
    @(negedge clock);
    reset_n = 1'b1;
    check_frame(0, w[3], 1'b0, 1'b0, -1, "rst next");
    no_read(0, 30, "rst");

    chk("read while empty", 64'(rd_empty), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
